// File: rtl/rip_mmu_mem_arbiter.sv
// Round-robin arbiter sharing one memory command port between MMU channel 1 (rd/wr) and channel 2 (rd).
// Optional watchdog enabled by defining RIP_MMU_ARB_TIMEOUT_EN.
module rip_mmu_mem_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int LINE_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_1,
   input  logic                      we_1,
   input  logic [ADDR_WIDTH-1:0]     addr_1,
   input  logic [LINE_WIDTH-1:0]     wdata_1,
   input  logic [LINE_WIDTH/8-1:0]   wstrb_1,
   output logic                      done_1,
   output logic [LINE_WIDTH-1:0]     rdata_1,
   input  logic                      req_2,
   input  logic [ADDR_WIDTH-1:0]     addr_2,
   output logic                      done_2,
   output logic [LINE_WIDTH-1:0]     rdata_2,
   output logic                      mem_valid,
   input  logic                      mem_ready,
   output logic                      mem_we,
   output logic [ADDR_WIDTH-1:0]     mem_addr,
   output logic [LINE_WIDTH-1:0]     mem_wdata,
   output logic [LINE_WIDTH/8-1:0]   mem_wstrb,
   input  logic                      mem_done,
   input  logic [LINE_WIDTH-1:0]     mem_rdata,
   output logic                      busy,
   output logic                      owner,
   output logic                      err
);

   localparam int STRB_W = LINE_WIDTH / 8;
   localparam int OFFS   = (STRB_W > 1) ? $clog2(STRB_W) : 0;

   typedef enum logic [1:0] {IDLE, CMD, WAIT, RESP} state_t;

   state_t state, state_nxt;
   logic   last_grant;
   logic   mask_en;
   logic   req_1_m, req_2_m, hazard, start, grant;
   logic   line_match;
   logic   cap, tmo_hit, tmo_fire;

   assign line_match = (addr_1[ADDR_WIDTH-1:OFFS] == addr_2[ADDR_WIDTH-1:OFFS]);

   // The port serviced last is hidden for one IDLE cycle so a registered req drop is not re-issued.
   always_comb begin
      req_1_m = req_1 && !(mask_en && !owner);
      req_2_m = req_2 && !(mask_en && owner);
      hazard  = req_1_m && we_1 && req_2_m && line_match;
      start   = req_1_m || req_2_m;
      grant   = 1'b0;
      if (hazard)
         grant = 1'b0;
      else if (req_1_m && !req_2_m)
         grant = 1'b0;
      else if (!req_1_m && req_2_m)
         grant = 1'b1;
      else
         grant = !last_grant;
   end

   assign cap      = ((state == CMD) && mem_ready && mem_done) || ((state == WAIT) && mem_done);
   assign tmo_fire = tmo_hit && !cap;

`ifdef RIP_MMU_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] tmo_cnt;
   logic             err_q;

   assign tmo_hit = ((state == CMD) || (state == WAIT)) &&
                    (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign err     = err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt <= '0;
         err_q   <= 1'b0;
      end else begin
         if (state == IDLE)
            tmo_cnt <= '0;
         else if ((state == CMD) || (state == WAIT))
            tmo_cnt <= tmo_cnt + 1'b1;
         if (tmo_fire)
            err_q <= 1'b1;
      end
   end
`else
   // Watchdog absent: never fires, waits are unbounded.
   assign tmo_hit = 1'b0 & (TIMEOUT_CYCLES > 0);
   assign err     = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = CMD;
         CMD: begin
            if (mem_ready && mem_done) state_nxt = RESP;
            else if (tmo_hit)          state_nxt = RESP;
            else if (mem_ready)        state_nxt = WAIT;
         end
         WAIT: if (mem_done || tmo_hit) state_nxt = RESP;
         RESP: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         mask_en    <= 1'b0;
         owner      <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_wstrb  <= '0;
         rdata_1    <= '0;
         rdata_2    <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE) begin
            mask_en <= 1'b0;
            if (start) begin
               owner     <= grant;
               mem_we    <= grant ? 1'b0 : we_1;
               mem_addr  <= grant ? addr_2 : addr_1;
               mem_wdata <= grant ? '0 : wdata_1;
               mem_wstrb <= grant ? '0 : wstrb_1;
            end
         end
         if (state == RESP) begin
            last_grant <= owner;
            mask_en    <= 1'b1;
         end
         if (cap && !mem_we) begin
            if (owner) rdata_2 <= mem_rdata;
            else       rdata_1 <= mem_rdata;
         end else if (tmo_fire) begin
            if (owner) rdata_2 <= '0;
            else       rdata_1 <= '0;
         end
      end
   end

   assign mem_valid = (state == CMD);
   assign busy      = (state != IDLE);
   assign done_1    = (state == RESP) && !owner;
   assign done_2    = (state == RESP) && owner;

endmodule

// File: tb/tb_rip_mmu_mem_arbiter.sv
// Directed bench for rip_mmu_mem_arbiter with a behavioural memory responder.
module tb_rip_mmu_mem_arbiter;

   localparam int AW  = 32;
   localparam int LW  = 32;
   localparam int SW  = LW / 8;
   localparam int TMO = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_1, we_1, req_2;
   logic [AW-1:0] addr_1, addr_2;
   logic [LW-1:0] wdata_1;
   logic [SW-1:0] wstrb_1;
   logic          done_1, done_2;
   logic [LW-1:0] rdata_1, rdata_2;
   logic          mem_valid, mem_ready, mem_we, mem_done;
   logic [AW-1:0] mem_addr;
   logic [LW-1:0] mem_wdata, mem_rdata;
   logic [SW-1:0] mem_wstrb;
   logic          busy, owner, err;

   rip_mmu_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst),
      .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1), .wstrb_1(wstrb_1),
      .done_1(done_1), .rdata_1(rdata_1),
      .req_2(req_2), .addr_2(addr_2), .done_2(done_2), .rdata_2(rdata_2),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_done(mem_done), .mem_rdata(mem_rdata),
      .busy(busy), .owner(owner), .err(err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] mem [0:63];
   int          ready_delay = 0, done_delay = 0, rdy_left = 0, done_left = 0;
   bit          no_done = 0, pending = 0;
   logic [31:0] pend_data;
   int          d1_cnt = 0, d2_cnt = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (done_1) d1_cnt++;
      if (done_2) d2_cnt++;
   end

   // Memory responder: accepts after ready_delay cycles, answers done_delay cycles after acceptance.
   initial begin
      logic [5:0] idx;
      mem_ready = 1'b0; mem_done = 1'b0; mem_rdata = '0;
      forever begin
         @(negedge clk);
         mem_ready = 1'b0; mem_done = 1'b0;
         if (rst) begin
            pending  = 0;
            rdy_left = ready_delay;
         end else if (pending) begin
            done_left--;
            if (done_left <= 0) begin
               mem_done = 1'b1; mem_rdata = pend_data; pending = 0;
            end
         end else if (mem_valid) begin
            if (rdy_left > 0) rdy_left--;
            else begin
               mem_ready = 1'b1;
               rdy_left  = ready_delay;
               idx = mem_addr[7:2];
               if (mem_we)
                  for (int b = 0; b < SW; b++)
                     if (mem_wstrb[b]) mem[idx][8*b +: 8] = mem_wdata[8*b +: 8];
               pend_data = mem[idx];
               if (!no_done) begin
                  if (done_delay == 0) begin
                     mem_done = 1'b1; mem_rdata = pend_data;
                  end else begin
                     pending = 1; done_left = done_delay;
                  end
               end
            end
         end
      end
   end

   task automatic wait_done(input int budget, output int ch, output int cycles, output int ncmd);
      logic prev;
      ch = 0; cycles = 0; ncmd = 0; prev = mem_valid;
      while (cycles < budget) begin
         @(negedge clk);
         cycles++;
         if (mem_valid && !prev) ncmd++;
         prev = mem_valid;
         if (done_1) begin ch = 1; break; end
         if (done_2) begin ch = 2; break; end
      end
      if (ch == 0) check("done_wait_expired", 0, 1);
   endtask

   initial begin
      int ch, cyc, nc, d1_snap;
      int exp_ch [4] = '{1, 2, 1, 2};
      for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
      mem[4] = 32'hcafe_cafe;
      rst = 1'b1; req_1 = 0; we_1 = 0; req_2 = 0;
      addr_1 = '0; addr_2 = '0; wdata_1 = '0; wstrb_1 = '0;

      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_valid", mem_valid, 0);
      check("rst_done", {done_1, done_2}, 0);
      check("rst_owner", owner, 0);
      check("rst_err", err, 0);
      @(negedge clk);
      rst = 1'b0;

      // Single channel-1 read with a delayed completion.
      done_delay = 3;
      @(negedge clk);
      req_1 = 1; we_1 = 0; addr_1 = 32'h10;
      check("t1_valid_pre", mem_valid, 0);
      @(negedge clk);
      check("t1_valid_lat", mem_valid, 1);
      check("t1_addr", mem_addr, 32'h10);
      check("t1_owner", owner, 0);
      wait_done(20, ch, cyc, nc);
      check("t1_ch", ch, 1);
      check("t1_done_lat", cyc, 4);
      check("t1_rdata", rdata_1, 32'hcafe_cafe);
      req_1 = 0;
      @(negedge clk);
      check("t1_pulse_len", done_1, 0);
      check("t1_no_done2", d2_cnt, 0);

      // Both channels held: strict alternation starting with channel 1 after reset.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      done_delay = 1;
      addr_1 = 32'h0; addr_2 = 32'h4; we_1 = 0;
      req_1 = 1; req_2 = 1;
      for (int k = 0; k < 4; k++) begin
         wait_done(30, ch, cyc, nc);
         check("t2_order", ch, exp_ch[k]);
         check("t2_owner", owner, exp_ch[k] - 1);
         check("t2_one_cmd", nc, 1);
         if (ch == 1) check("t2_rdata1", rdata_1, 32'h1000_0000);
         else         check("t2_rdata2", rdata_2, 32'h1000_0001);
      end
      req_1 = 0; req_2 = 0;

      // Hazard: write on channel 1 beats a same-line read on channel 2 despite the pointer.
      @(negedge clk);
      req_1 = 1; addr_1 = 32'h0;
      wait_done(30, ch, cyc, nc);
      check("t3_pre_ch", ch, 1);
      req_1 = 0;
      @(negedge clk);
      @(negedge clk);
      req_1 = 1; we_1 = 1; addr_1 = 32'h20; wdata_1 = 32'hdead_beef; wstrb_1 = 4'b1111;
      req_2 = 1; addr_2 = 32'h20;
      @(negedge clk);
      check("t3_owner", owner, 0);
      check("t3_we", mem_we, 1);
      check("t3_addr", mem_addr, 32'h20);
      check("t3_wdata", mem_wdata, 32'hdead_beef);
      wait_done(30, ch, cyc, nc);
      check("t3_first", ch, 1);
      req_1 = 0; we_1 = 0;
      wait_done(30, ch, cyc, nc);
      check("t3_second", ch, 2);
      check("t3_rdata2", rdata_2, 32'hdead_beef);
      check("t3_rdata1_kept", rdata_1, 32'h1000_0000);
      req_2 = 0;

      // Backpressure: command fields stable while mem_ready is low.
      @(negedge clk);
      ready_delay = 5; rdy_left = 5;
      req_1 = 1; we_1 = 1; addr_1 = 32'h30; wdata_1 = 32'h1234_5678; wstrb_1 = 4'b0011;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t4_valid", mem_valid, 1);
         check("t4_addr", mem_addr, 32'h30);
         check("t4_wdata", mem_wdata, 32'h1234_5678);
         check("t4_we", mem_we, 1);
         check("t4_no_done", done_1, 0);
      end
      wait_done(30, ch, cyc, nc);
      check("t4_ch", ch, 1);
      check("t4_done_lat", cyc, 3);
      check("t4_rdata1_kept", rdata_1, 32'h1000_0000);
      check("t4_mem", mem[12], 32'h1000_5678);
      req_1 = 0; we_1 = 0; wstrb_1 = '0;
      ready_delay = 0; rdy_left = 0;

      // Asynchronous reset while waiting for completion.
      @(negedge clk);
      done_delay = 10;
      req_1 = 1; addr_1 = 32'h40;
      repeat (3) @(negedge clk);
      check("t5_busy_pre", busy, 1);
      #2 rst = 1'b1;
      #1;
      check("t5_busy", busy, 0);
      check("t5_valid", mem_valid, 0);
      check("t5_owner", owner, 0);
      check("t5_addr", mem_addr, 0);
      check("t5_rdata1", rdata_1, 0);
      check("t5_rdata2", rdata_2, 0);
      check("t5_done", {done_1, done_2}, 0);
      req_1 = 0;
      d1_snap = d1_cnt;
      @(negedge clk);
      #1 rst = 1'b0;
      repeat (12) @(negedge clk);
      check("t5_no_done", d1_cnt, d1_snap);
      done_delay = 1;
      req_2 = 1; addr_2 = 32'h8;
      @(negedge clk);
      check("t5_owner2", owner, 1);
      check("t5_addr2", mem_addr, 32'h8);
      wait_done(30, ch, cyc, nc);
      check("t5_ch", ch, 2);
      check("t5_rdata2b", rdata_2, 32'h1000_0002);
      req_2 = 0;

`ifdef RIP_MMU_ARB_TIMEOUT_EN
      @(negedge clk);
      req_1 = 1; addr_1 = 32'h10;
      wait_done(30, ch, cyc, nc);
      check("t6_pre_rdata", rdata_1, 32'hcafe_cafe);
      req_1 = 0;
      @(negedge clk);
      @(negedge clk);
      no_done = 1;
      req_1 = 1; addr_1 = 32'h10;
      @(negedge clk);
      check("t6_valid", mem_valid, 1);
      wait_done(40, ch, cyc, nc);
      check("t6_ch", ch, 1);
      check("t6_lat", cyc, TMO);
      check("t6_rdata", rdata_1, 0);
      check("t6_err", err, 1);
      req_1 = 0; no_done = 0;
      @(negedge clk);
      req_2 = 1; addr_2 = 32'h8;
      wait_done(30, ch, cyc, nc);
      check("t6_next_ch", ch, 2);
      check("t6_err_sticky", err, 1);
      req_2 = 0;
      rst = 1'b1;
      #1 check("t6_err_clr", err, 0);
      @(negedge clk);
      rst = 1'b0;
`else
      check("err_tied", err, 0);
`endif

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/rip_mmu_mem_arbiter.md
Name: rip_mmu_mem_arbiter

Overview:
- Shares one downstream memory command port between the MMU's two channels: channel 1 (read/write, line refill and write-back) and channel 2 (read-only, refill).
- Sits between the per-channel cache miss logic and the AXI master adapter.
- Allows one transaction in flight at a time.
- Arbitration is round-robin, with a write-before-read hazard override so that neither channel can deadlock the other.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- LINE_WIDTH, 32, bits per transfer (cache line); multiple of 8, power of two.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_1  in  1  channel 1 request level; held until done_1
- we_1  in  1  channel 1 write (1) / read (0)
- addr_1  in  ADDR_WIDTH  channel 1 address
- wdata_1  in  LINE_WIDTH  channel 1 write data
- wstrb_1  in  LINE_WIDTH/8  channel 1 byte strobes
- done_1  out  1  one-cycle completion pulse, channel 1
- rdata_1  out  LINE_WIDTH  channel 1 read data
- req_2  in  1  channel 2 read request level
- addr_2  in  ADDR_WIDTH  channel 2 address
- done_2  out  1  one-cycle completion pulse, channel 2
- rdata_2  out  LINE_WIDTH  channel 2 read data
- mem_valid  out  1  command valid
- mem_ready  in  1  command accepted
- mem_we  out  1  command is a write
- mem_addr  out  ADDR_WIDTH  command address
- mem_wdata  out  LINE_WIDTH  write data
- mem_wstrb  out  LINE_WIDTH/8  write strobes
- mem_done  in  1  completion pulse from downstream
- mem_rdata  in  LINE_WIDTH  read data, valid with mem_done
- busy  out  1  high in any state except IDLE
- owner  out  1  0 = channel 1, 1 = channel 2; valid while busy
- err  out  1  sticky timeout flag

Behaviour:
- Reset: clk is the only clock; rst is asynchronous and active-high. All outputs are forced to 0, state goes to IDLE, and the last-grant pointer is set to channel 2.
- Reset mid-transaction abandons the transaction silently; no done pulse is issued.
- FSM states: IDLE -> CMD -> WAIT -> RESP -> IDLE.
- IDLE:
  - Sample req_1/req_2.
  - Winner selection, in priority order:
    - Hazard rule: req_1 && we_1 && req_2 and the line addresses match (addr bits above log2(LINE_WIDTH/8)) -> channel 1 wins.
    - Otherwise, if only one channel requests, it wins.
    - Otherwise the channel not granted last wins.
  - Latch the winner's we/addr/wdata/wstrb (channel 2 forces we=0, wstrb=0) and go to CMD.
- CMD:
  - mem_valid=1; all mem_* fields are stable until mem_valid && mem_ready.
  - On acceptance: go to WAIT, or straight to RESP if mem_done is high in the same cycle (capture rdata).
- WAIT:
  - On mem_done: capture mem_rdata into the owner's rdata register and go to RESP.
  - mem_done outside CMD/WAIT is ignored.
- RESP:
  - Pulse done_<owner> for exactly one cycle and update the last-grant pointer to owner.
  - rdata_x holds its value until that channel's next read completes; writes leave rdata_1 unchanged.
- Requester masking: the port just serviced is masked in the first IDLE cycle after RESP. This lets a requester that samples done at the clock edge drop req registered without a spurious re-issue. The other port may be granted in that cycle.
- Latency: req seen in IDLE at cycle N -> mem_valid at N+1. With mem_ready and mem_done both in the N+1 cycle, done_x is at N+2.
- Simultaneous done/new req: not possible, because a single outstanding transaction is enforced. A req arriving mid-transaction waits in its level.
- Deadlock freedom: channel 2 is never blocked on a channel 1 read. An in-flight transaction always completes before arbitration.

Optional Feature:
- Macro RIP_MMU_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to CMD and increments in CMD/WAIT.
  - On reaching TIMEOUT_CYCLES: set err (sticky until rst), drop mem_valid, write 0 to the owner's rdata, and go to RESP, so the owner still receives done.
- Undefined: no counter exists, err is tied to 0, and WAIT/CMD wait indefinitely.

Test Plan:
- Read channel 1 @0x10; mem_ready immediate, mem_done 3 cycles later with 0xcafecafe -> mem_valid one cycle after req, single done_1 pulse, rdata_1=0xcafecafe, done_2 stays 0.
- req_1 and req_2 both held (reads @0x0/@0x4) across 4 completions -> grant order 1,2,1,2, owner toggles accordingly, never two mem_valid commands overlapping.
- After a channel 1 grant, channel 1 writes 0xdeadbeef wstrb 4'b1111 @0x20 while channel 2 reads @0x20 in the same cycle -> the write is issued first despite the pointer, then the read returns 0xdeadbeef on rdata_2.
- mem_ready held low 5 cycles during CMD -> mem_valid high and mem_addr/mem_wdata/mem_we constant all 5 cycles; no done until acceptance plus mem_done.
- rst pulsed during WAIT -> all outputs 0 asynchronously, no done pulse; a subsequent channel 2 read @0x8 completes normally (channel 1 is not favoured by a stale pointer).
- With the macro defined and TIMEOUT_CYCLES=16: channel 1 read with mem_done never asserted -> done_1 about 16 cycles after CMD entry, rdata_1=0, err=1 and held through subsequent transactions until rst.
